scurve_sweep_ctrl: RTL
======================

# scurve_sweep_ctrl

Sequencer that runs a full S-curve threshold sweep for one channel by driving the per-trigger pulse/trigger counter stage directly downstream of the DAC. For each threshold code it loads the DAC, waits for it to settle, clears and starts the counter stage, and waits for its done flag. It then captures the pulse and trigger counts and pushes a 3-word record into the readout FIFO. It consumes `CPT_PULSE`, `CPT_TRIGGER` and `CPT_DONE` and produces `Test_Start` and the counter-stage reset.

## Interface

Parameters:
- `DAC_WIDTH`, 10: threshold DAC code width. Record format requires ≤ 10.
- `SETTLE_CYCLES`, 100: Clk cycles waited after each DAC load. Must be ≥ 1.
- `TIMEOUT_CYCLES`, 24'd10_000_000: RUN watchdog limit. Used only with `SCURVE_TIMEOUT_EN`.

Ports:
- `Clk` in 1: the single clock.
- `reset_n` in 1: synchronous, active-low reset.
- `Sweep_Start` in 1: one-cycle start request, honoured only in IDLE.
- `Sweep_Abort` in 1: synchronous abort, any state.
- `DAC_Start` in DAC_WIDTH: first code.
- `DAC_Stop` in DAC_WIDTH: last code.
- `DAC_Step` in DAC_WIDTH: increment; 0 is treated as 1.
- `Channel` in 6: channel id placed in the trailer.
- `CPT_PULSE` in 16: pulse count from the counter stage.
- `CPT_TRIGGER` in 16: trigger count from the counter stage.
- `CPT_DONE` in 1: counter stage done flag.
- `Test_Start` out 1: enables the counter stage.
- `Test_Reset_n` out 1: active-low clear pulse to the counter stage.
- `DAC_Code` out DAC_WIDTH: current threshold code.
- `DAC_Load` out 1: one-cycle DAC write strobe.
- `Fifo_Data` out 16: record word.
- `Fifo_WrEn` out 1: write strobe.
- `Fifo_Full` in 1: FIFO backpressure.
- `Sweep_Busy` out 1: high in every state except IDLE.
- `Sweep_Done` out 1: one-cycle pulse on normal completion.

## Operation

- **States:** IDLE, LOAD, SETTLE, CLR, RUN, WRITE, TRAIL.
- **IDLE:**
  - On `Sweep_Start`: `DAC_Code` ← `DAC_Start`, latch `DAC_Stop`, `DAC_Step` and `Channel`, go to LOAD.
  - Input changes mid-sweep are ignored.
- **LOAD:** `DAC_Load` = 1 for exactly one cycle, then SETTLE.
- **SETTLE:** count `SETTLE_CYCLES` cycles, then CLR.
- **CLR:** `Test_Reset_n` = 0 for exactly 2 cycles, then RUN.
- **RUN:**
  - `Test_Start` = 1.
  - On the first cycle with `CPT_DONE` = 1: capture `CPT_PULSE` and `CPT_TRIGGER`, drop `Test_Start` on the next cycle, go to WRITE.
- **WRITE:** emit 3 words in order:
  - W0 = {4'hA, 1'b0, to_flag, `DAC_Code`}
  - W1 = captured pulse count
  - W2 = captured trigger count
  - A word is written (`Fifo_WrEn` = 1) only in a cycle where `Fifo_Full` = 0. Otherwise hold `Fifo_Data` and the word index.
- **Next point:** computed in DAC_WIDTH+1 bits: next = `DAC_Code` + step.
  - If `DAC_Code` == stop, or next > stop, or next ≥ 2^DAC_WIDTH: go to TRAIL.
  - Else `DAC_Code` ← next and go to LOAD.
- **TRAIL:** write {8'hFF, 2'b00, Channel} under the same backpressure rule, pulse `Sweep_Done`, go to IDLE.
- **`DAC_Start` > `DAC_Stop`:** exactly one point is measured at `DAC_Start`, then the trailer.
- **`Sweep_Abort`:** next cycle is IDLE, `Test_Start` = 0, no further FIFO writes, no trailer, no `Sweep_Done`. A word being written in the abort cycle still completes. Abort has priority over every other transition.

## Timing

- **Reset values:**
  - `Test_Start` = 0, `Test_Reset_n` = 1, `DAC_Code` = 0.
  - `DAC_Load` = 0, `Fifo_Data` = 0, `Fifo_WrEn` = 0.
  - `Sweep_Busy` = 0, `Sweep_Done` = 0, state = IDLE.
- **Reset mid-sweep:** all outputs take reset values on the next edge. Partial records are not completed.
- **`Sweep_Start` at edge n:**
  - `DAC_Load` high in cycle n+1.
  - SETTLE covers n+2 … n+1+`SETTLE_CYCLES`.
  - `Test_Reset_n` low for the next 2 cycles.
  - `Test_Start` rises in the following cycle.
- **`CPT_DONE` sampled high at edge m:** counts are registered at edge m, `Test_Start` = 0 after edge m, W0 can be written in cycle m+1.
- **Without backpressure:** W0..W2 occupy 3 consecutive cycles.
- **All outputs are registered.** No combinational path from any input to any output.

## Configuration

- **`SCURVE_TIMEOUT_EN` defined:** a 24-bit watchdog counts RUN cycles.
  - Reaching `TIMEOUT_CYCLES` without `CPT_DONE` captures the current counts, sets to_flag = 1 in W0, and proceeds to WRITE normally.
  - The watchdog clears on RUN entry.
- **Not defined:** no watchdog logic. RUN waits indefinitely and to_flag is constant 0.

## Test plan

- **Nominal sweep:** Start=100, Stop=104, Step=2, Channel=5, bench counter returns PULSE=1000, TRIGGER=code*3 → records for 100, 102, 104 (W0 = 0xA064, 0xA066, 0xA068), then trailer 0xFF05, one `Sweep_Done`.
- **Inverted range and zero step:**
  - Start=50, Stop=40 → one record (W0=0xA032) plus trailer.
  - Step=0, Start=Stop=7 → one record.
- **Backpressure:** `Fifo_Full` high for 5 cycles during W1 → W1 held, no `Fifo_WrEn` while full, W1/W2 written in order after release, no words lost or duplicated.
- **Wrap:** Start=1020, Stop=1023, Step=5 → a single point at 1020, then trailer; `DAC_Code` never wraps to a low value.
- **Abort/reset:**
  - `Sweep_Abort` in RUN → IDLE next cycle, `Test_Start` = 0, no trailer.
  - `reset_n` low in WRITE → all outputs at reset values after the edge.
- **Timeout (macro on):** `TIMEOUT_CYCLES`=50, `CPT_DONE` held low → record with W0 bit 10 = 1, `Test_Start` high exactly 50 RUN cycles.

Source files
------------

// File: rtl/scurve_sweep_ctrl_if.sv
// Sweep controller bus: run parameters, counter-stage handshake, DAC and FIFO side.
// The controller uses the master modport and the environment uses the slave modport.
interface scurve_sweep_ctrl_if #(
  parameter int DAC_WIDTH = 10
);
  logic                 Sweep_Start;
  logic                 Sweep_Abort;
  logic [DAC_WIDTH-1:0] DAC_Start;
  logic [DAC_WIDTH-1:0] DAC_Stop;
  logic [DAC_WIDTH-1:0] DAC_Step;
  logic [5:0]           Channel;
  logic [15:0]          CPT_PULSE;
  logic [15:0]          CPT_TRIGGER;
  logic                 CPT_DONE;
  logic                 Test_Start;
  logic                 Test_Reset_n;
  logic [DAC_WIDTH-1:0] DAC_Code;
  logic                 DAC_Load;
  logic [15:0]          Fifo_Data;
  logic                 Fifo_WrEn;
  logic                 Fifo_Full;
  logic                 Sweep_Busy;
  logic                 Sweep_Done;

  modport master (
    input  Sweep_Start, Sweep_Abort, DAC_Start, DAC_Stop, DAC_Step, Channel,
    input  CPT_PULSE, CPT_TRIGGER, CPT_DONE, Fifo_Full,
    output Test_Start, Test_Reset_n, DAC_Code, DAC_Load,
    output Fifo_Data, Fifo_WrEn, Sweep_Busy, Sweep_Done
  );

  modport slave (
    output Sweep_Start, Sweep_Abort, DAC_Start, DAC_Stop, DAC_Step, Channel,
    output CPT_PULSE, CPT_TRIGGER, CPT_DONE, Fifo_Full,
    input  Test_Start, Test_Reset_n, DAC_Code, DAC_Load,
    input  Fifo_Data, Fifo_WrEn, Sweep_Busy, Sweep_Done
  );
endinterface

// File: rtl/scurve_sweep_ctrl.sv
// S-curve threshold sweep sequencer: per code load DAC, settle, clear/run counter stage, write 3-word record; trailer at end.
// All outputs registered; FIFO writes stall on Fifo_Full. Define SCURVE_TIMEOUT_EN to add the RUN watchdog.
module scurve_sweep_ctrl #(
  parameter int          DAC_WIDTH      = 10,
  parameter int          SETTLE_CYCLES  = 100,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd10_000_000
) (
  input  logic                 Clk,
  input  logic                 reset_n,
  scurve_sweep_ctrl_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SETTLE, S_CLR, S_RUN, S_WRITE, S_TRAIL
  } state_t;

  state_t               r_state;
  logic [31:0]          r_cnt;
  logic [1:0]           r_widx;
  logic [DAC_WIDTH-1:0] r_code;
  logic [DAC_WIDTH-1:0] r_stop;
  logic [DAC_WIDTH-1:0] r_step;
  logic [5:0]           r_chan;
  logic [15:0]          r_pulse;
  logic [15:0]          r_trig;

  logic [DAC_WIDTH:0]   w_next;
  logic                 w_last;
  logic [9:0]           w_code10;
  logic                 w_to;
  logic                 w_capture;
  logic                 w_cap_to;
  logic [15:0]          w_word;

`ifdef SCURVE_TIMEOUT_EN
  logic                 r_to;
  logic [23:0]          r_wdog;
  logic                 w_wdog_hit;

  assign w_wdog_hit = (r_wdog == TIMEOUT_CYCLES - 24'd1);
  assign w_to       = r_to;
  assign w_capture  = bus.CPT_DONE || w_wdog_hit;
  assign w_cap_to   = !bus.CPT_DONE;
`else
  assign w_to       = 1'b0;
  assign w_capture  = bus.CPT_DONE;
  assign w_cap_to   = 1'b0;
`endif

  // The extra top bit of w_next catches codes that would run past the DAC range.
  assign w_next   = {1'b0, r_code} + {1'b0, r_step};
  assign w_last   = (r_code == r_stop) || (w_next > {1'b0, r_stop}) || w_next[DAC_WIDTH];
  assign w_code10 = 10'(r_code);

  always_comb begin
    w_word = r_trig;
    case (r_widx)
      2'd0:    w_word = {4'hA, 1'b0, w_to, w_code10};
      2'd1:    w_word = r_pulse;
      default: w_word = r_trig;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!reset_n) begin
      r_state          <= S_IDLE;
      r_cnt            <= '0;
      r_widx           <= '0;
      r_code           <= '0;
      r_stop           <= '0;
      r_step           <= '0;
      r_chan           <= '0;
      r_pulse          <= '0;
      r_trig           <= '0;
`ifdef SCURVE_TIMEOUT_EN
      r_to             <= 1'b0;
      r_wdog           <= '0;
`endif
      bus.Test_Start   <= 1'b0;
      bus.Test_Reset_n <= 1'b1;
      bus.DAC_Code     <= '0;
      bus.DAC_Load     <= 1'b0;
      bus.Fifo_Data    <= '0;
      bus.Fifo_WrEn    <= 1'b0;
      bus.Sweep_Busy   <= 1'b0;
      bus.Sweep_Done   <= 1'b0;
    end else begin
      bus.DAC_Load   <= 1'b0;
      bus.Fifo_WrEn  <= 1'b0;
      bus.Sweep_Done <= 1'b0;
      if (bus.Sweep_Abort) begin
        r_state          <= S_IDLE;
        bus.Test_Start   <= 1'b0;
        bus.Test_Reset_n <= 1'b1;
        bus.Sweep_Busy   <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (bus.Sweep_Start) begin
              r_code         <= bus.DAC_Start;
              r_stop         <= bus.DAC_Stop;
              r_step         <= (bus.DAC_Step == '0) ? DAC_WIDTH'(1) : bus.DAC_Step;
              r_chan         <= bus.Channel;
              bus.DAC_Code   <= bus.DAC_Start;
              bus.DAC_Load   <= 1'b1;
              bus.Sweep_Busy <= 1'b1;
              r_state        <= S_LOAD;
            end
          end
          S_LOAD: begin
            r_cnt   <= '0;
            r_state <= S_SETTLE;
          end
          S_SETTLE: begin
            if (r_cnt == 32'(SETTLE_CYCLES - 1)) begin
              r_cnt            <= '0;
              bus.Test_Reset_n <= 1'b0;
              r_state          <= S_CLR;
            end else begin
              r_cnt <= r_cnt + 32'd1;
            end
          end
          S_CLR: begin
            if (r_cnt == 32'd1) begin
              bus.Test_Reset_n <= 1'b1;
              bus.Test_Start   <= 1'b1;
`ifdef SCURVE_TIMEOUT_EN
              r_wdog           <= '0;
`endif
              r_state          <= S_RUN;
            end else begin
              r_cnt <= r_cnt + 32'd1;
            end
          end
          S_RUN: begin
            if (w_capture) begin
              r_pulse        <= bus.CPT_PULSE;
              r_trig         <= bus.CPT_TRIGGER;
`ifdef SCURVE_TIMEOUT_EN
              r_to           <= w_cap_to;
`endif
              bus.Test_Start <= 1'b0;
              r_state        <= S_WRITE;
              // W0 needs no captured count, so it can go out right behind the capture.
              if (!bus.Fifo_Full) begin
                bus.Fifo_WrEn <= 1'b1;
                bus.Fifo_Data <= {4'hA, 1'b0, w_cap_to, w_code10};
                r_widx        <= 2'd1;
              end else begin
                r_widx <= 2'd0;
              end
            end
`ifdef SCURVE_TIMEOUT_EN
            else begin
              r_wdog <= r_wdog + 24'd1;
            end
`endif
          end
          S_WRITE: begin
            if (!bus.Fifo_Full) begin
              bus.Fifo_WrEn <= 1'b1;
              bus.Fifo_Data <= w_word;
              if (r_widx == 2'd2) begin
                r_widx <= 2'd0;
                if (w_last) begin
                  r_state <= S_TRAIL;
                end else begin
                  r_code       <= w_next[DAC_WIDTH-1:0];
                  bus.DAC_Code <= w_next[DAC_WIDTH-1:0];
                  bus.DAC_Load <= 1'b1;
                  r_state      <= S_LOAD;
                end
              end else begin
                r_widx <= r_widx + 2'd1;
              end
            end
          end
          S_TRAIL: begin
            if (!bus.Fifo_Full) begin
              bus.Fifo_WrEn  <= 1'b1;
              bus.Fifo_Data  <= {8'hFF, 2'b00, r_chan};
              bus.Sweep_Done <= 1'b1;
              bus.Sweep_Busy <= 1'b0;
              r_state        <= S_IDLE;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
